// File: rtl/inst_fetch.sv
// Instruction fetch stage: holds the fetch PC and a direct-mapped instruction
// cache. On a miss it fetches one word through the arbiter handshake, fills
// the cache, then the hit path delivers it to the decoder. A ROB flush
// redirects the PC and kills the outstanding fetch.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | look up pc; on hit feed the output slot, on miss go fetch
// WAIT_MEM | request pc from the arbiter until the response pulse
`timescale 1ns/1ps

module inst_fetch #(
    parameter int          ICACHE_INDEX_WIDTH = 8,
    parameter logic [31:0] RESET_PC           = 32'h0
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    output logic        mem_en_out,
    output logic [31:0] mem_pc_out,
    input  logic        mem_en_in,
    input  logic [31:0] mem_inst_in,
    output logic        dec_en_out,
    output logic [31:0] dec_inst_out,
    output logic [31:0] dec_pc_out,
    input  logic        dec_rdy_in,
    input  logic        rob_flush_in,
    input  logic [31:0] rob_pc_in
);

    localparam int LINES = 1 << ICACHE_INDEX_WIDTH;
    localparam int TAG_W = 30 - ICACHE_INDEX_WIDTH;

    typedef enum logic {
        IDLE     = 1'b0,
        WAIT_MEM = 1'b1
    } state_t;

    state_t state, state_next;

    logic [31:0] pc, pc_next;
    logic        dec_en_next;
    logic [31:0] dec_inst_next, dec_pc_next;

    logic [LINES-1:0] valid;
    logic [TAG_W-1:0] tag_arr  [LINES];
    logic [31:0]      data_arr [LINES];

    logic [ICACHE_INDEX_WIDTH-1:0] index;
    logic [TAG_W-1:0]              tag;
    logic                          hit;
    logic                          out_free;
    logic                          fill;

    assign index    = pc[ICACHE_INDEX_WIDTH+1:2];
    assign tag      = pc[31:ICACHE_INDEX_WIDTH+2];
    assign hit      = valid[index] && (tag_arr[index] == tag);
    assign out_free = !dec_en_out || dec_rdy_in;

    // Request drops in the response cycle so the arbiter never restarts the same fetch.
    assign mem_en_out = (state == WAIT_MEM) && !mem_en_in && !rob_flush_in;
    assign mem_pc_out = {pc[31:2], 2'b00};

    // Next-state, next-PC and output-slot decisions; flush beats everything else.
    always_comb begin
        state_next    = state;
        pc_next       = pc;
        dec_en_next   = dec_en_out;
        dec_inst_next = dec_inst_out;
        dec_pc_next   = dec_pc_out;
        fill          = 1'b0;

        if (rob_flush_in) begin
            pc_next     = rob_pc_in;
            state_next  = IDLE;
            dec_en_next = 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (hit) begin
                        if (out_free) begin
                            dec_en_next   = 1'b1;
                            dec_inst_next = data_arr[index];
                            dec_pc_next   = pc;
                            pc_next       = pc + 32'd4;
                        end
                    end else begin
                        state_next = WAIT_MEM;
                        if (out_free) begin
                            dec_en_next = 1'b0;
                        end
                    end
                end
                WAIT_MEM: begin
                    if (out_free) begin
                        dec_en_next = 1'b0;
                    end
                    if (mem_en_in) begin
                        fill       = 1'b1;
                        state_next = IDLE;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    // Control registers and valid bits; rdy_in low freezes everything.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state        <= IDLE;
            pc           <= RESET_PC;
            dec_en_out   <= 1'b0;
            dec_inst_out <= 32'h0;
            dec_pc_out   <= 32'h0;
            valid        <= '0;
        end else if (rdy_in) begin
            state        <= state_next;
            pc           <= pc_next;
            dec_en_out   <= dec_en_next;
            dec_inst_out <= dec_inst_next;
            dec_pc_out   <= dec_pc_next;
            if (fill) begin
                valid[index] <= 1'b1;
            end
        end
    end

    // Tag and data arrays carry no reset so they can map onto RAM.
    always_ff @(posedge clk_in) begin
        if (!rst_in && rdy_in && fill) begin
            tag_arr[index]  <= tag;
            data_arr[index] <= mem_inst_in;
        end
    end

endmodule

// File: tb/tb_inst_fetch.sv
// Bench for inst_fetch: arbiter responder model, directed scenarios and a
// randomized phase, with a scoreboard that checks the decoder stream in
// program order and that every memory request is a real cache miss.
`timescale 1ns/1ps

module tb_inst_fetch;

    logic        clk_in = 1'b0;
    logic        rst_in, rdy_in;
    logic        mem_en_out;
    logic [31:0] mem_pc_out;
    logic        mem_en_in;
    logic [31:0] mem_inst_in;
    logic        dec_en_out;
    logic [31:0] dec_inst_out, dec_pc_out;
    logic        dec_rdy_in;
    logic        rob_flush_in;
    logic [31:0] rob_pc_in;

    int n_tests = 0;
    int n_fail  = 0;
    int n_xfer  = 0;
    int n_req   = 0;

    // responder state
    int          lat;
    int          cnt;
    logic        pulse_next;
    logic [31:0] resp_addr;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] next_pc;
    logic [31:0] line_addr[int];
    logic        req_active;
    logic [31:0] req_addr;

    inst_fetch dut (
        .clk_in      (clk_in),
        .rst_in      (rst_in),
        .rdy_in      (rdy_in),
        .mem_en_out  (mem_en_out),
        .mem_pc_out  (mem_pc_out),
        .mem_en_in   (mem_en_in),
        .mem_inst_in (mem_inst_in),
        .dec_en_out  (dec_en_out),
        .dec_inst_out(dec_inst_out),
        .dec_pc_out  (dec_pc_out),
        .dec_rdy_in  (dec_rdy_in),
        .rob_flush_in(rob_flush_in),
        .rob_pc_in   (rob_pc_in)
    );

    always #5 clk_in = ~clk_in;

    // Instruction memory contents as a pure function of the address.
    function automatic logic [31:0] memfn(input logic [31:0] a);
        if (a == 32'h0) return 32'h0000_0013;
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drv();
        @(posedge clk_in);
        #1;
    endtask

    task automatic smp();
        @(negedge clk_in);
        #1;
    endtask

    task automatic flush_to(input logic [31:0] addr);
        drv();
        rob_flush_in = 1'b1;
        rob_pc_in    = addr;
        drv();
        rob_flush_in = 1'b0;
        rob_pc_in    = $urandom;
    endtask

    task automatic expect_miss(input string name, input logic [31:0] addr);
        smp();
        check({name, "_idle"}, {31'b0, mem_en_out}, 32'd0);
        drv();
        smp();
        check({name, "_req"}, {31'b0, mem_en_out}, 32'd1);
        check({name, "_addr"}, mem_pc_out, addr);
    endtask

    task automatic wait_deliver(input logic [31:0] addr);
        logic found;
        found = 1'b0;
        for (int k = 0; k < 200; k++) begin
            smp();
            if (dec_en_out && dec_rdy_in && rdy_in && dec_pc_out == addr) begin
                found = 1'b1;
                break;
            end
        end
        check("deliver_wait", {31'b0, found}, 32'd1);
    endtask

    // Arbiter model: responds lat cycles after the request is seen.
    initial begin
        cnt         = 0;
        pulse_next  = 1'b0;
        resp_addr   = 32'h0;
        mem_en_in   = 1'b0;
        mem_inst_in = 32'h0;
        forever begin
            @(negedge clk_in);
            if (rst_in || !mem_en_out) begin
                cnt = 0;
            end else begin
                cnt++;
                if (cnt >= lat) begin
                    pulse_next = 1'b1;
                    resp_addr  = mem_pc_out;
                    cnt        = 0;
                end
            end
            @(posedge clk_in);
            #1;
            mem_en_in   = pulse_next;
            mem_inst_in = pulse_next ? memfn(resp_addr) : $urandom;
            pulse_next  = 1'b0;
        end
    end

    // Scoreboard monitor: program-order stream and miss-only requests.
    initial begin
        exp_t e;
        int   ia;
        logic cached;
        next_pc    = 32'h0;
        req_active = 1'b0;
        req_addr   = 32'h0;
        forever begin
            @(negedge clk_in);
            if (rst_in) begin
                exp_q.delete();
                line_addr.delete();
                next_pc    = 32'h0;
                req_active = 1'b0;
            end else begin
                if (mem_en_out && !req_active) begin
                    ia     = int'(mem_pc_out[9:2]);
                    cached = line_addr.exists(ia) && (line_addr[ia] == mem_pc_out);
                    check("req_on_miss", {31'b0, cached}, 32'd0);
                    req_active = 1'b1;
                    req_addr   = mem_pc_out;
                    n_req++;
                end
                if (rdy_in) begin
                    if (dec_en_out && dec_rdy_in) begin
                        e = exp_q.pop_front();
                        check("stream_pc", dec_pc_out, e.pc);
                        check("stream_inst", dec_inst_out, e.inst);
                        n_xfer++;
                    end
                    if (rob_flush_in) begin
                        exp_q.delete();
                        next_pc    = rob_pc_in;
                        req_active = 1'b0;
                    end else if (mem_en_in && req_active) begin
                        line_addr[int'(req_addr[9:2])] = req_addr;
                        req_active = 1'b0;
                    end
                end
            end
            while (exp_q.size() < 4) begin
                e.pc   = next_pc;
                e.inst = memfn(next_pc);
                exp_q.push_back(e);
                next_pc = next_pc + 32'd4;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Directed scenarios followed by randomized traffic.
    initial begin
        logic        s_en, s_men;
        logic [31:0] s_pc, s_inst, s_mpc;
        logic        found;

        rst_in       = 1'b1;
        rdy_in       = 1'b1;
        dec_rdy_in   = 1'b1;
        rob_flush_in = 1'b0;
        rob_pc_in    = 32'h0;
        lat          = 5;

        // reset values
        drv();
        drv();
        smp();
        check("rst_dec_en", {31'b0, dec_en_out}, 32'd0);
        check("rst_dec_pc", dec_pc_out, 32'h0);
        check("rst_dec_inst", dec_inst_out, 32'h0);
        check("rst_mem_en", {31'b0, mem_en_out}, 32'd0);

        // first miss: 5 request cycles, drop in pulse cycle, deliver 2 later
        drv();
        rst_in = 1'b0;
        smp();
        check("first_idle", {31'b0, mem_en_out}, 32'd0);
        smp();
        for (int i = 0; i < 5; i++) begin
            check("miss_req_high", {31'b0, mem_en_out}, 32'd1);
            check("miss_req_addr", mem_pc_out, 32'h0);
            smp();
        end
        check("pulse_req_drop", {31'b0, mem_en_out}, 32'd0);
        check("pulse_seen", {31'b0, mem_en_in}, 32'd1);
        smp();
        check("deliver_p1_en", {31'b0, dec_en_out}, 32'd0);
        smp();
        check("deliver_p2_en", {31'b0, dec_en_out}, 32'd1);
        check("deliver_p2_pc", dec_pc_out, 32'h0);
        check("deliver_p2_inst", dec_inst_out, 32'h13);

        // warm 0x0..0xC, then replay at one per cycle with no requests
        lat = 2;
        wait_deliver(32'hC);
        flush_to(32'h0);
        smp();
        check("replay_flush_en", {31'b0, dec_en_out}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            smp();
            check("replay_en", {31'b0, dec_en_out}, 32'd1);
            check("replay_pc", dec_pc_out, 32'(i * 4));
            check("replay_no_req", {31'b0, mem_en_out}, 32'd0);
        end

        // decoder stall for 3 cycles
        flush_to(32'h0);
        smp();
        drv();
        dec_rdy_in = 1'b0;
        for (int i = 0; i < 3; i++) begin
            smp();
            check("stall_en", {31'b0, dec_en_out}, 32'd1);
            check("stall_pc", dec_pc_out, 32'h0);
            check("stall_inst", dec_inst_out, 32'h13);
            check("stall_fetch_pc", mem_pc_out, 32'h4);
        end
        drv();
        dec_rdy_in = 1'b1;
        smp();
        check("stall_release_pc", dec_pc_out, 32'h0);
        smp();
        check("resume_en", {31'b0, dec_en_out}, 32'd1);
        check("resume_pc", dec_pc_out, 32'h4);

        // flush coinciding with the response pulse
        lat = 3;
        flush_to(32'h300);
        expect_miss("miss_300", 32'h300);
        found = 1'b0;
        for (int k = 0; k < 30; k++) begin
            smp();
            if (pulse_next) begin
                found = 1'b1;
                break;
            end
        end
        check("pulse_wait", {31'b0, found}, 32'd1);
        drv();
        rob_flush_in = 1'b1;
        rob_pc_in    = 32'h100;
        smp();
        check("flush_pulse_coincide", {31'b0, mem_en_in}, 32'd1);
        check("flush_req_drop", {31'b0, mem_en_out}, 32'd0);
        drv();
        rob_flush_in = 1'b0;
        smp();
        check("flush_dec_en", {31'b0, dec_en_out}, 32'd0);
        check("flush_new_pc", mem_pc_out, 32'h100);
        smp();
        check("flush_req_en", {31'b0, mem_en_out}, 32'd1);
        check("flush_req_addr", mem_pc_out, 32'h100);
        wait_deliver(32'h100);
        flush_to(32'h300);
        expect_miss("no_fill_on_flush", 32'h300);

        // aliasing lines 0x000 / 0x400
        flush_to(32'h400);
        expect_miss("alias_400", 32'h400);
        wait_deliver(32'h400);
        flush_to(32'h0);
        expect_miss("alias_000", 32'h0);
        wait_deliver(32'h0);

        // global enable low for 4 cycles mid hit stream
        flush_to(32'h0);
        smp();
        smp();
        drv();
        rdy_in = 1'b0;
        smp();
        check("freeze_first_pc", dec_pc_out, 32'h4);
        s_en   = dec_en_out;
        s_pc   = dec_pc_out;
        s_inst = dec_inst_out;
        s_men  = mem_en_out;
        s_mpc  = mem_pc_out;
        for (int i = 0; i < 3; i++) begin
            smp();
            check("freeze_en", {31'b0, dec_en_out}, {31'b0, s_en});
            check("freeze_pc", dec_pc_out, s_pc);
            check("freeze_inst", dec_inst_out, s_inst);
            check("freeze_mem_en", {31'b0, mem_en_out}, {31'b0, s_men});
            check("freeze_mem_pc", mem_pc_out, s_mpc);
        end
        drv();
        rdy_in = 1'b1;
        smp();
        check("thaw_pc", dec_pc_out, 32'h4);
        smp();
        check("thaw_next_pc", dec_pc_out, 32'h8);

        // randomized traffic; the scoreboard monitor does the checking
        for (int c = 0; c < 3000; c++) begin
            drv();
            rst_in       = ($urandom_range(0, 499) == 0);
            rdy_in       = ($urandom_range(0, 9) != 0);
            dec_rdy_in   = ($urandom_range(0, 3) != 0);
            rob_flush_in = ($urandom_range(0, 29) == 0);
            rob_pc_in    = (32'($urandom_range(0, 3)) << 10) | (32'($urandom_range(0, 15)) << 2);
            if (c % 200 == 0) lat = $urandom_range(1, 6);
        end
        drv();
        rst_in       = 1'b0;
        rdy_in       = 1'b1;
        dec_rdy_in   = 1'b1;
        rob_flush_in = 1'b0;
        repeat (20) drv();
        check("random_progress", {31'b0, (n_xfer > 300)}, 32'd1);
        check("random_requests", {31'b0, (n_req > 20)}, 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/inst_fetch.md
Name: inst_fetch

Overview:
- Instruction fetch stage directly upstream of the memory-port arbiter's IF channel.
- Holds the architectural fetch PC and a direct-mapped instruction cache.
- On a miss, requests a 32-bit instruction through the arbiter's IF request/response handshake, fills the cache, then delivers instructions one per cycle to the decoder through a valid/ready output register.
- A ROB flush redirects the PC and kills in-flight work.

Parameters:
- ICACHE_INDEX_WIDTH, 8, log2 of cache lines; one 32-bit instruction per line.
- RESET_PC, 32'h0, PC loaded on reset.

Ports:
- clk_in  input  1  clock.
- rst_in  input  1  synchronous active-high reset.
- rdy_in  input  1  global enable; when low, all state holds.
- mem_en_out  output  1  fetch request to arbiter (combinational).
- mem_pc_out  output  32  request address, word aligned.
- mem_en_in  input  1  one-cycle response-valid pulse from arbiter.
- mem_inst_in  input  32  fetched instruction, valid with mem_en_in.
- dec_en_out  output  1  instruction valid to decoder (registered).
- dec_inst_out  output  32  instruction.
- dec_pc_out  output  32  PC of dec_inst_out.
- dec_rdy_in  input  1  decoder accepts this cycle.
- rob_flush_in  input  1  mispredict/exception flush.
- rob_pc_in  input  32  redirect target, valid with rob_flush_in.

Behaviour:
- Clock and reset: one clock, clk_in. rst_in is synchronous, active-high, and overrides rdy_in.
- Reset values:
  - pc = RESET_PC; state = IDLE.
  - dec_en_out = 0; dec_inst_out = 0; dec_pc_out = 0.
  - All cache valid bits = 0. Tag/data arrays need no reset.
- Cache addressing:
  - index = pc[ICACHE_INDEX_WIDTH+1:2].
  - tag = pc[31:ICACHE_INDEX_WIDTH+2].
  - hit = valid[index] && tag_arr[index] == tag. Evaluated combinationally from the pc register.
- Output slot:
  - out_free = !dec_en_out || dec_rdy_in.
  - A transfer occurs at a posedge with dec_en_out && dec_rdy_in.
  - When the slot is held and not free, dec_inst_out and dec_pc_out stay stable.
- FSM states: IDLE, WAIT_MEM.
- IDLE:
  - hit && out_free: dec_inst_out <= data_arr[index]; dec_pc_out <= pc; dec_en_out <= 1; pc <= pc + 4 (32-bit wrap). Stay IDLE. Sustained throughput is 1 instruction per cycle.
  - hit && !out_free: hold all state.
  - miss: go to WAIT_MEM, independent of out_free.
  - If out_free and no new instruction is loaded: dec_en_out <= 0.
- WAIT_MEM:
  - mem_en_out = (state == WAIT_MEM) && !mem_en_in && !rob_flush_in, combinational. It drops in the same cycle as the response pulse so the arbiter does not restart the same fetch.
  - mem_pc_out = pc, held stable for the whole request.
  - On mem_en_in: data_arr[index] <= mem_inst_in; tag_arr[index] <= tag; valid[index] <= 1; state <= IDLE.
  - The instruction is then delivered by the IDLE hit path next cycle, so miss-to-decoder latency is response + 2 cycles.
  - The output slot still drains normally while waiting.
- Flush (rdy_in && rob_flush_in, highest priority after reset):
  - pc <= rob_pc_in; state <= IDLE; dec_en_out <= 0.
  - A mem_en_in arriving in the same cycle is discarded, with no cache write.
  - Cache contents are retained.
- rdy_in low: no register or array update. mem_en_out still follows the formula.
- Replacement: always overwrite the indexed line; aliasing PCs evict each other.
- Reset mid-miss: returns to IDLE with mem_en_out = 0 in the following cycle. All valid bits are cleared.

Test Plan:
- Reset, memory model returns 32'h00000013 for pc 0 after 5 cycles -> mem_en_out high with mem_pc_out = 0 until the pulse, low in the pulse cycle; dec_en_out = 1, dec_pc_out = 0, dec_inst_out = 32'h13 two cycles after the pulse.
- Straight-line loop over 0x0..0xC pre-warmed, dec_rdy_in = 1 -> four consecutive dec_en_out cycles with PCs 0, 4, 8, 0xC and no mem_en_out.
- Warm hits with dec_rdy_in held low 3 cycles -> dec_pc_out/dec_inst_out stable, pc not advanced; resumes with the next PC on the first ready cycle.
- Flush to 0x100 during WAIT_MEM with the response pulse in the same cycle -> no cache write, dec_en_out = 0, next request is mem_pc_out = 0x100.
- Aliasing with index width 8: fetch 0x000 then 0x400 then 0x000 -> three misses; the third re-requests 0x000.
- rdy_in low for 4 cycles mid-hit-stream -> no outputs change; stream continues in order afterwards.
